// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM block and its prescaler.
package pwm_pkg;
    typedef enum logic {MODE_EDGE, MODE_CENTER} pwm_mode_t;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;
    localparam int DVSR_W = 32;
endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every dvsr+1 clk cycles while enabled, held at phase 0 when disabled.
module pwm_prescaler
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick
);

    logic [DVSR_W-1:0] q;

    // >= lets a lowered divisor wrap immediately instead of running the counter out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (!en || q >= dvsr)
            q <= '0;
        else
            q <= q + DVSR_W'(1);
    end

    assign tick = en && (q == '0);

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM with shared prescaler and period counter, edge/center modes, and
// double-buffered period/mode/duty that switch over only at a period boundary.
//   state    | meaning
//   DIR_UP   | counter rising 0 -> period_a (always the mode in edge alignment)
//   DIR_DOWN | counter falling period_a-1 -> 0 (center alignment only)
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int W = 10,
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [DVSR_W-1:0]  dvsr,
    input  logic [W-1:0]       period,
    input  logic               center,
    input  logic [N*(W+1)-1:0] duty,
    input  logic [N-1:0]       pol,
    input  logic               load,
    output logic               pend,
    output logic               bnd,
    output logic [N-1:0]       pwm_out
);

    logic               tick;
    logic               boundary;
    logic               upd;
    logic [W-1:0]       c, c_nx;
    pwm_dir_t           dir, dir_nx;
    logic [W-1:0]       period_a, period_s;
    pwm_mode_t          mode_a, mode_s;
    logic [N*(W+1)-1:0] duty_a, duty_s;
    logic [N-1:0]       raw;

    pwm_prescaler u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .dvsr  (dvsr),
        .tick  (tick)
    );

    always_comb begin
        c_nx     = c;
        dir_nx   = dir;
        boundary = 1'b0;
        if (!en) begin
            c_nx   = '0;
            dir_nx = DIR_UP;
        end else if (tick) begin
            if (mode_a == MODE_EDGE || period_a == '0) begin
                boundary = (c >= period_a);
                c_nx     = boundary ? '0 : c + W'(1);
                dir_nx   = DIR_UP;
            end else if (dir == DIR_DOWN) begin
                if (c <= W'(1)) begin
                    boundary = 1'b1;
                    c_nx     = '0;
                    dir_nx   = DIR_UP;
                end else begin
                    c_nx = c - W'(1);
                end
            end else if (c >= period_a) begin
                // Period 1 never reaches c==1 on the way down, so its top is the boundary.
                if (period_a == W'(1)) begin
                    boundary = 1'b1;
                    c_nx     = '0;
                end else begin
                    c_nx   = c - W'(1);
                    dir_nx = DIR_DOWN;
                end
            end else begin
                c_nx = c + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c   <= '0;
            dir <= DIR_UP;
            bnd <= 1'b0;
        end else begin
            c   <= c_nx;
            dir <= dir_nx;
            bnd <= boundary;
        end
    end

    // While disabled the counter sits at 0, so any update can be applied at once.
    assign upd = boundary || !en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_a <= '0;
            period_s <= '0;
            mode_a   <= MODE_EDGE;
            mode_s   <= MODE_EDGE;
            duty_a   <= '0;
            duty_s   <= '0;
            pend     <= 1'b0;
        end else begin
            if (load) begin
                period_s <= period;
                mode_s   <= pwm_mode_t'(center);
                duty_s   <= duty;
            end
            if (upd && load) begin
                period_a <= period;
                mode_a   <= pwm_mode_t'(center);
                duty_a   <= duty;
                pend     <= 1'b0;
            end else if (upd && pend) begin
                period_a <= period_s;
                mode_a   <= mode_s;
                duty_a   <= duty_s;
                pend     <= 1'b0;
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        assign raw[gi] = ({1'b0, c} < duty_a[gi*(W+1) +: W+1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pwm_out <= '0;
        else if (!en)
            pwm_out <= pol;
        else
            pwm_out <= raw ^ pol;
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Randomized and directed bench for pwm_multi against a period-position reference model.
module tb_pwm_multi;
    localparam int W  = 10;
    localparam int N  = 4;
    localparam int DW = W + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [31:0]        dvsr;
    logic [W-1:0]       period;
    logic               center;
    logic [N*DW-1:0]    duty;
    logic [N-1:0]       pol;
    logic               load;
    logic               pend;
    logic               bnd;
    logic [N-1:0]       pwm_out;

    pwm_multi #(.W(W), .N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .dvsr    (dvsr),
        .period  (period),
        .center  (center),
        .duty    (duty),
        .pol     (pol),
        .load    (load),
        .pend    (pend),
        .bnd     (bnd),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: prescaler phase, position t within the period, active/shadow config.
    logic [31:0] m_q;
    int          m_t;
    int          m_p, s_p;
    bit          m_ctr, s_ctr;
    int          m_duty[N];
    int          s_duty[N];
    bit          m_pend, m_bnd;
    logic [N-1:0] m_out;

    int hi_cnt[N];
    int bnd_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int period_len();
        return (m_ctr && m_p != 0) ? 2 * m_p : m_p + 1;
    endfunction

    function automatic bit next_is_boundary();
        return en && (m_q == 0) && (m_t == period_len() - 1);
    endfunction

    task automatic model_reset();
        m_q = 0; m_t = 0; m_p = 0; s_p = 0; m_ctr = 0; s_ctr = 0;
        m_pend = 0; m_bnd = 0; m_out = '0;
        for (int i = 0; i < N; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
    endtask

    task automatic model_edge();
        bit tk, bn, upd;
        int c, len;
        tk  = en && (m_q == 0);
        len = period_len();
        bn  = tk && (m_t == len - 1);
        c   = (m_ctr && m_p != 0 && m_t > m_p) ? 2 * m_p - m_t : m_t;
        for (int i = 0; i < N; i++)
            m_out[i] = en ? ((c < m_duty[i]) ^ pol[i]) : pol[i];
        if (!en || m_q >= dvsr) m_q = 0; else m_q = m_q + 1;
        if (!en) m_t = 0; else if (tk) m_t = bn ? 0 : m_t + 1;
        upd = bn || !en;
        if (upd && load) begin
            m_p = int'(period); m_ctr = center; m_pend = 0;
            for (int i = 0; i < N; i++) m_duty[i] = int'(duty[i*DW +: DW]);
        end else if (upd && m_pend) begin
            m_p = s_p; m_ctr = s_ctr; m_pend = 0;
            for (int i = 0; i < N; i++) m_duty[i] = s_duty[i];
        end else if (load) begin
            m_pend = 1;
        end
        if (load) begin
            s_p = int'(period); s_ctr = center;
            for (int i = 0; i < N; i++) s_duty[i] = int'(duty[i*DW +: DW]);
        end
        m_bnd = bn;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(m_out));
        chk("pend", 32'(pend), 32'(m_pend));
        chk("bnd", 32'(bnd), 32'(m_bnd));
        for (int i = 0; i < N; i++) hi_cnt[i] += int'(pwm_out[i]);
        bnd_cnt += int'(bnd);
        load = 1'b0;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N; i++) hi_cnt[i] = 0;
        bnd_cnt = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_bnd", 32'(bnd), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_duty(input int ch, input int v);
        duty[ch*DW +: DW] = DW'(v);
    endtask

    task automatic rand_cfg();
        period = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 10));
        center = 1'($urandom_range(0, 1));
        for (int i = 0; i < N; i++)
            set_duty(i, ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 12)));
    endtask

    initial begin
        int guard;
        reset = 1'b1; en = 1'b0; dvsr = 0; period = 0; center = 0;
        duty = '0; pol = '0; load = 1'b0;
        model_reset();
        clr_counts();
        #12;
        chk("init_pwm", 32'(pwm_out), 32'd0);
        chk("init_pend", 32'(pend), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Edge mode, 10-clk period, 3 clk high.
        period = 9; set_duty(0, 3); load = 1'b1;
        step();
        en = 1'b1;
        run(20);
        clr_counts(); run(20);
        chk("edge_high", hi_cnt[0], 6);
        chk("edge_bnd", bnd_cnt, 2);

        // Center mode, dvsr=1, period 4 -> 16 clks, 6 high on channel 1.
        dvsr = 1; period = 4; center = 1; set_duty(1, 2); load = 1'b1;
        run(20);
        clr_counts(); run(32);
        chk("ctr_high", hi_cnt[1], 12);
        chk("ctr_bnd", bnd_cnt, 2);

        // Duty limits with both polarities.
        dvsr = 0; period = 9; center = 0;
        set_duty(0, 0); set_duty(1, 10); set_duty(2, 2047); set_duty(3, 5);
        load = 1'b1;
        run(30);
        clr_counts(); run(20);
        chk("lim_d0", hi_cnt[0], 0);
        chk("lim_d10", hi_cnt[1], 20);
        chk("lim_d2047", hi_cnt[2], 20);
        pol = 4'hF;
        run(2);
        clr_counts(); run(20);
        chk("limi_d0", hi_cnt[0], 20);
        chk("limi_d10", hi_cnt[1], 0);
        chk("limi_d2047", hi_cnt[2], 0);
        pol = '0;

        // Mid-period load 3 -> 7 at c=4.
        set_duty(0, 3); load = 1'b1;
        guard = 0;
        while (!next_is_boundary() && guard < 50) begin step(); guard++; end
        chk("wait_bnd1", 32'(guard < 50), 32'd1);
        run(5);
        set_duty(0, 7); load = 1'b1;
        step();
        chk("mid_pend", 32'(pend), 32'd1);
        run(12);

        // Load exactly in the boundary cycle: straight to active.
        guard = 0;
        while (!next_is_boundary() && guard < 50) begin step(); guard++; end
        chk("wait_bnd2", 32'(guard < 50), 32'd1);
        set_duty(0, 2); load = 1'b1;
        step();
        chk("bload_pend", 32'(pend), 32'd0);
        run(12);

        // dvsr lowered from 100 to 5 while the prescaler is mid-way.
        dvsr = 100; period = 3; set_duty(0, 2); load = 1'b1;
        guard = 0;
        while (m_q != 50 && guard < 300) begin step(); guard++; end
        chk("wait_q50", 32'(guard < 300), 32'd1);
        dvsr = 5;
        run(60);

        // Reset mid-period, then disabled behaviour.
        dvsr = 0; period = 9; set_duty(0, 3); load = 1'b1;
        run(15);
        do_reset();
        pol = 4'b1010; en = 1'b0;
        run(5);
        chk("dis_pol", 32'(pwm_out), 32'(4'b1010));
        period = 5; set_duty(0, 4); load = 1'b1;
        run(4);
        en = 1'b1;
        run(15);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 3) dvsr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
            if ($urandom_range(0, 99) < 4) begin rand_cfg(); load = 1'b1; end
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 99) < 3) pol = N'($urandom_range(0, 15));
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- N-channel PWM generator with a shared prescaler and a shared period counter, for LED dimming and motor drive on the board.
- Each channel has its own duty value and output polarity.
- Supports edge-aligned and center-aligned modes and a programmable period.
- Duty, period and mode updates are double-buffered so that they take effect only at a period boundary (glitch-free).

Parameters:
- W, 10: period counter width; period range 0..2^W-1.
- N, 4: number of PWM channels.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global enable; 0 holds the counters and forces outputs to their inactive level.
- dvsr  in  32  prescaler divisor; one counter tick every dvsr+1 clk cycles.
- period  in  W  period register value (shadowed).
- center  in  1  mode select, 0 = edge-aligned, 1 = center-aligned (shadowed).
- duty  in  N*(W+1)  per-channel duty, channel i at bits [i*(W+1)+W : i*(W+1)] (shadowed).
- pol  in  N  per-channel polarity, 1 = active-low output (live, not shadowed).
- load  in  1  single-cycle pulse; captures period, center and duty into the shadow registers.
- pend  out  1  shadow contents are waiting for the next boundary.
- bnd  out  1  one-cycle pulse at each period boundary.
- pwm_out  out  N  registered PWM outputs.

Behaviour:
- Reset (async): prescaler q=0, counter c=0, dir=up, pend=0, bnd=0.
  - Active and shadow registers: period=0, center=0, duty=0.
  - pwm_out=0 during reset; from the first enabled cycle after reset, an idle channel drives pol[i].
- Prescaler:
  - q_next = (q >= dvsr) ? 0 : q+1; tick = (q==0).
  - Using >= means a dvsr decrease below the current q wraps on the next cycle instead of running to 2^32.
  - dvsr=0 gives a tick every clk.
- Edge mode counter, on tick:
  - c = (c==period_a) ? 0 : c+1.
  - Boundary = tick && c==period_a. Period length is period_a+1 ticks.
- Center mode counter, on tick:
  - Counts 0→period_a while dir=up, then period_a-1→0 while dir=down.
  - dir flips at c==period_a (to down) and at c==0 (to up).
  - Boundary = tick && c==1 && dir==down, i.e. the next c is 0. Period length is 2*period_a ticks.
  - period_a=0 in center mode behaves as edge mode with period 0.
- Compare:
  - raw_i = ({1'b0,c} < duty_a[i]); pwm_out[i] <= raw_i ^ pol[i].
  - Output is registered: 1 clk after c changes.
  - duty_a=0 → constant inactive.
  - Edge mode: duty_a > period_a → constant active; otherwise high for duty_a ticks per period.
  - Center mode: high for 2*duty_a-1 ticks per period (1 ≤ duty_a ≤ period_a), symmetric about c=0.
- Shadow and active registers:
  - load captures period, center and duty into the shadow registers and sets pend=1.
  - At a boundary with pend=1: active <= shadow, pend <= 0, c <= 0, dir <= up.
  - load in the same cycle as a boundary: the new input values go straight to active (bypass) and pend stays 0.
  - A second load before the boundary overwrites the shadow contents (last one wins).
- bnd: registered, high for one clk the cycle after the boundary tick.
- en=0:
  - q, c and dir are held at 0/up; pwm_out = pol; bnd=0.
  - Shadow loads still accepted. While disabled, a load with pend goes to active immediately.
  - On en 0→1: counting starts at c=0 with the first tick on the next cycle.
- Reset mid-period: everything is cleared immediately; any pending shadow contents are lost.

Decomposition:
- pwm_pkg:
  - typedef enum logic {MODE_EDGE, MODE_CENTER} pwm_mode_t;
  - typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;
  - localparam DVSR_W = 32.
- Sub-module pwm_prescaler (dvsr, en → tick), reusable by other timer blocks.
- Channel compare: generate loop in the top module.

Test Plan:
- Edge mode, dvsr=0, period=9, duty[0]=3, pol=0, load, en=1 → pwm_out[0] high 3 of every 10 clks; bnd every 10 clks.
- Center mode, dvsr=1, period=4, duty[1]=2, load → period 16 clks; pwm_out[1] high 6 clks per period, centred on c=0; bnd every 16 clks.
- Limits, period=9: duty=0 → constant 0; duty=10 and duty=2047 → constant 1; pol=1 inverts all three cases.
- Mid-period load of duty 3→7 at c=4 → pend=1, old waveform to period end; first cycle with c=0 uses duty 7; pend clears with bnd.
- load in the boundary cycle → new duty active in that period, pend never asserts. dvsr changed from 100 to 5 while q=50 → q wraps next clk, then ticks every 6 clks.
- Reset asserted mid-period → pwm_out=0, pend=0, c=0 asynchronously. en=0 → pwm_out=pol and the counter frozen at 0.
